adpll_lock_controller: RTL

- Supervises the phase-detector output stream of the ADPLL.
- Consumes each saved signed phase-error sample (in FPGA clock cycles) and sequences acquisition, tracking and lock.
- Selects the loop-filter gain, and issues the filter update strobe with the sample.
- Flags lock, lock loss, and a watchdog fault when samples stop arriving.

---
 rtl/adpll_lock_controller.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/adpll_lock_controller.sv
// ---------------------------------------------------------------------------
// adpll_lock_controller
//
// Supervises the ADPLL phase-detector sample stream. Each accepted signed
// phase-error sample is forwarded to the loop filter together with a gain
// selection that follows the acquisition state:
//   IDLE -> ACQUIRE (wide gain) -> TRACK (narrow) -> LOCKED (narrow)
// A watchdog forces a sticky FAULT when samples stop arriving.
//
// Ports:
//   fpga_clk_i       system clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   enable_i         level; low forces IDLE on the next edge
//   pd_valid_i       one-cycle strobe qualifying pd_phase_i
//   pd_phase_i       signed phase error sample
//   filter_update_o  one-cycle strobe to the loop filter
//   filter_phase_o   sample forwarded with filter_update_o
//   gain_sel_o       00 none, 01 wide, 10 narrow
//   locked_o         high while LOCKED
//   lock_lost_o      one-cycle pulse when LOCKED is left with enable_i high
//   fault_o          high while FAULT
//   state_o          IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3, FAULT=4
// ---------------------------------------------------------------------------
module adpll_lock_controller #(
  parameter int WIDTH         = 20,
  parameter int COARSE_WINDOW = 64,
  parameter int LOCK_WINDOW   = 8,
  parameter int ACQ_COUNT     = 4,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int TIMEOUT       = 1000000
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    pd_valid_i,
  input  logic signed [WIDTH-1:0] pd_phase_i,
  output logic                    filter_update_o,
  output logic signed [WIDTH-1:0] filter_phase_o,
  output logic [1:0]              gain_sel_o,
  output logic                    locked_o,
  output logic                    lock_lost_o,
  output logic                    fault_o,
  output logic [2:0]              state_o
);

  localparam int GOOD_MAX = (ACQ_COUNT > LOCK_COUNT) ? ACQ_COUNT : LOCK_COUNT;
  localparam int GOOD_W   = $clog2(GOOD_MAX + 1);
  localparam int BAD_W    = $clog2(UNLOCK_COUNT + 1);
  localparam int WD_W     = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0]  COARSE_LIM = WIDTH'(COARSE_WINDOW);
  localparam logic [WIDTH-1:0]  LOCK_LIM   = WIDTH'(LOCK_WINDOW);
  localparam logic [GOOD_W-1:0] ACQ_N      = GOOD_W'(ACQ_COUNT);
  localparam logic [GOOD_W-1:0] LOCK_N     = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] GOOD_SAT   = GOOD_W'(GOOD_MAX);
  localparam logic [BAD_W-1:0]  UNLOCK_N   = BAD_W'(UNLOCK_COUNT);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic                upd_q, upd_d;
  logic [WIDTH-1:0]    phase_q, phase_d;
  logic [1:0]          gain_q, gain_d;
  logic                locked_q, locked_d;
  logic                lost_q, lost_d;
  logic                fault_q, fault_d;

  // Saturating magnitude: the most negative code has no positive twin, so it
  // is clamped to the most positive one.
  logic [WIDTH-1:0]    abs_phase;
  logic                in_lock, in_coarse;
  logic [GOOD_W-1:0]   good_inc;
  logic [BAD_W-1:0]    bad_inc;

  always_comb begin
    abs_phase = pd_phase_i;
    if (pd_phase_i[WIDTH-1]) begin
      if (pd_phase_i == MOST_NEG) abs_phase = MOST_POS;
      else                        abs_phase = ~pd_phase_i + WIDTH'(1);
    end
  end

  assign in_lock   = (abs_phase <= LOCK_LIM);
  assign in_coarse = (abs_phase <= COARSE_LIM);
  assign good_inc  = (good_q >= GOOD_SAT) ? good_q : good_q + GOOD_W'(1);
  assign bad_inc   = (bad_q >= UNLOCK_N)  ? bad_q  : bad_q + BAD_W'(1);

  // Next state, counters and next output values.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    wd_d    = wd_q;
    upd_d   = 1'b0;
    phase_d = phase_q;

    if (!enable_i) begin
      state_d = ST_IDLE;
      good_d  = '0;
      bad_d   = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          good_d  = '0;
          bad_d   = '0;
          wd_d    = '0;
        end
        ST_ACQ, ST_TRACK, ST_LOCKED: begin
          if (pd_valid_i) begin
            upd_d   = 1'b1;
            phase_d = pd_phase_i;
            wd_d    = '0;
            case (state_q)
              ST_ACQ: begin
                if (!in_coarse) begin
                  good_d = '0;
                end else if (good_inc >= ACQ_N) begin
                  state_d = ST_TRACK;
                  good_d  = '0;
                end else begin
                  good_d = good_inc;
                end
              end
              ST_TRACK: begin
                if (in_lock) begin
                  if (good_inc >= LOCK_N) begin
                    state_d = ST_LOCKED;
                    good_d  = '0;
                    bad_d   = '0;
                  end else begin
                    good_d = good_inc;
                  end
                end else if (in_coarse) begin
                  good_d = '0;
                end else begin
                  state_d = ST_ACQ;
                  good_d  = '0;
                end
              end
              default: begin  // ST_LOCKED
                if (in_lock) begin
                  bad_d = '0;
                end else if (!in_coarse || bad_inc >= UNLOCK_N) begin
                  state_d = ST_ACQ;
                  good_d  = '0;
                  bad_d   = '0;
                end else begin
                  bad_d = bad_inc;
                end
              end
            endcase
          end else if (wd_q == WD_LAST) begin
            // A sample in this very cycle would have taken the branch above.
            state_d = ST_FAULT;
            good_d  = '0;
            bad_d   = '0;
            wd_d    = '0;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
          bad_d   = '0;
          wd_d    = '0;
        end
      endcase
    end

    case (state_d)
      ST_ACQ:              gain_d = 2'b01;
      ST_TRACK, ST_LOCKED: gain_d = 2'b10;
      default:             gain_d = 2'b00;
    endcase

    locked_d = (state_d == ST_LOCKED);
    fault_d  = (state_d == ST_FAULT);
    // Leaving LOCKED through a disable is an operator action, not a loss.
    lost_d   = enable_i && (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      good_q   <= '0;
      bad_q    <= '0;
      wd_q     <= '0;
      upd_q    <= 1'b0;
      phase_q  <= '0;
      gain_q   <= 2'b00;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      wd_q     <= wd_d;
      upd_q    <= upd_d;
      phase_q  <= phase_d;
      gain_q   <= gain_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
      fault_q  <= fault_d;
    end
  end

  assign filter_update_o = upd_q;
  assign filter_phase_o  = phase_q;
  assign gain_sel_o      = gain_q;
  assign locked_o        = locked_q;
  assign lock_lost_o     = lost_q;
  assign fault_o         = fault_q;
  assign state_o         = state_q;

endmodule
